io_arb: RTL and testbench

IO_ARB -- requirements
Module: io_arb

---
 rtl/io_arb_if.sv | 30 +++
 rtl/io_arb.sv | 90 +++++++++
 tb/tb_io_arb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_arb_if.sv
// Bundles the requester, response and downstream byte handshakes of io_arb.
// The master side is the environment (requesters plus downstream device); io_arb itself is the slave side.
interface io_arb_if;
  logic       r0_req_vld, r1_req_vld;
  logic       r0_req_is_in, r1_req_is_in;
  logic [7:0] r0_req_data, r1_req_data;
  logic       r0_req_rdy, r1_req_rdy;
  logic       r0_rsp_vld, r1_rsp_vld;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [7:0] io_out_data;
  logic       io_out_vld, io_out_rdy;
  logic [7:0] io_in_data;
  logic       io_in_vld, io_in_rdy;

  modport master (
    output r0_req_vld, r1_req_vld, r0_req_is_in, r1_req_is_in, r0_req_data, r1_req_data,
    output io_out_rdy, io_in_data, io_in_vld,
    input  r0_req_rdy, r1_req_rdy, r0_rsp_vld, r1_rsp_vld, rsp_data, rsp_err, busy,
    input  io_out_data, io_out_vld, io_in_rdy
  );

  modport slave (
    input  r0_req_vld, r1_req_vld, r0_req_is_in, r1_req_is_in, r0_req_data, r1_req_data,
    input  io_out_rdy, io_in_data, io_in_vld,
    output r0_req_rdy, r1_req_rdy, r0_rsp_vld, r1_rsp_vld, rsp_data, rsp_err, busy,
    output io_out_data, io_out_vld, io_in_rdy
  );
endinterface

// File: rtl/io_arb.sv
// Two-requester round-robin arbiter in front of one byte-wide IO port.
// One transaction is outstanding at a time, with an optional downstream handshake timeout.
module io_arb #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic     clk,
  input  logic     rst,
  io_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT, RESP} state_t;

  localparam bit        TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic        last;   // 1: r1 was granted most recently
  logic        own;    // 1: r1 owns the outstanding transaction
  logic [15:0] cnt;

  logic       idle, gnt0, gnt1, sel_is_in, hs, to_hit;
  logic [7:0] sel_data;

  always_comb begin
    idle      = (state == IDLE);
    gnt0      = idle & bus.r0_req_vld & (~bus.r1_req_vld | last);
    gnt1      = idle & bus.r1_req_vld & (~bus.r0_req_vld | ~last);
    sel_is_in = gnt1 ? bus.r1_req_is_in : bus.r0_req_is_in;
    sel_data  = gnt1 ? bus.r1_req_data  : bus.r0_req_data;
    hs        = (state == OUT_WAIT) ? bus.io_out_rdy : bus.io_in_vld;
    to_hit    = TO_EN && (cnt == TO_LAST);
  end

  assign bus.r0_req_rdy = gnt0;
  assign bus.r1_req_rdy = gnt1;
  assign bus.busy       = ~idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last            <= 1'b1;
      own             <= 1'b0;
      cnt             <= '0;
      bus.io_out_vld  <= 1'b0;
      bus.io_out_data <= '0;
      bus.io_in_rdy   <= 1'b0;
      bus.r0_rsp_vld  <= 1'b0;
      bus.r1_rsp_vld  <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            own  <= gnt1;
            last <= gnt1;
            cnt  <= '0;
            if (sel_is_in) begin
              bus.io_in_rdy <= 1'b1;
              state         <= IN_WAIT;
            end else begin
              bus.io_out_vld  <= 1'b1;
              bus.io_out_data <= sel_data;
              state           <= OUT_WAIT;
            end
          end
        end
        OUT_WAIT, IN_WAIT: begin
          // A handshake on the expiry edge still completes normally.
          if (hs | to_hit) begin
            bus.io_out_vld <= 1'b0;
            bus.io_in_rdy  <= 1'b0;
            bus.rsp_data   <= (hs && state == IN_WAIT) ? bus.io_in_data : 8'h00;
            bus.rsp_err    <= ~hs;
            bus.r0_rsp_vld <= ~own;
            bus.r1_rsp_vld <= own;
            state          <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          bus.r0_rsp_vld <= 1'b0;
          bus.r1_rsp_vld <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_arb.sv
// Scenario bench for io_arb: expected responses are queued at grant time and popped on rsp_vld.
module tb_io_arb;
  logic clk, rst;
  io_arb_if bus();

  io_arb #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {logic own; logic [7:0] data; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  int vec = 0, miscmp = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.r0_req_vld = 0; bus.r1_req_vld = 0; bus.r0_req_is_in = 0; bus.r1_req_is_in = 0;
    bus.r0_req_data = 0; bus.r1_req_data = 0;
    bus.io_out_rdy = 0; bus.io_in_vld = 0; bus.io_in_data = 0;
    #1;
    vec++; if (bus.busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vec++; if (bus.io_out_vld !== 1'b0 || bus.io_in_rdy !== 1'b0) begin miscmp++; $display("FAIL reset_io: got out_vld=%b in_rdy=%b want 0 0", bus.io_out_vld, bus.io_in_rdy); end
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld, bus.rsp_err} !== 3'b000) begin miscmp++; $display("FAIL reset_rsp: got %b want 000", {bus.r0_rsp_vld, bus.r1_rsp_vld, bus.rsp_err}); end
    vec++; if ({bus.rsp_data, bus.io_out_data} !== 16'h0000) begin miscmp++; $display("FAIL reset_data: got %h want 0000", {bus.rsp_data, bus.io_out_data}); end
    cyc(); cyc();
    rst = 0;
    #1;
    vec++; if ({bus.r0_req_rdy, bus.r1_req_rdy} !== 2'b00) begin miscmp++; $display("FAIL idle_no_rdy: got %b want 00", {bus.r0_req_rdy, bus.r1_req_rdy}); end
  endtask

  task automatic test_out_single();
    bus.io_out_rdy = 1;
    bus.r0_req_vld = 1; bus.r0_req_is_in = 0; bus.r0_req_data = 8'h41;
    #1;
    vec++; if ({bus.r0_req_rdy, bus.r1_req_rdy} !== 2'b10) begin miscmp++; $display("FAIL out_grant: got %b want 10", {bus.r0_req_rdy, bus.r1_req_rdy}); end
    sb.push_back('{1'b0, 8'h00, 1'b0});
    cyc();
    bus.r0_req_vld = 0;
    bus.r1_req_vld = 1; bus.r1_req_is_in = 0; bus.r1_req_data = 8'h99;
    #1;
    vec++; if (bus.io_out_vld !== 1'b1 || bus.io_out_data !== 8'h41) begin miscmp++; $display("FAIL out_drive: got vld=%b data=%h want 1 41", bus.io_out_vld, bus.io_out_data); end
    vec++; if (bus.r1_req_rdy !== 1'b0 || bus.busy !== 1'b1) begin miscmp++; $display("FAIL wait_no_rdy: got rdy=%b busy=%b want 0 1", bus.r1_req_rdy, bus.busy); end
    cyc();
    e = sb.pop_front();
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld} !== {~e.own, e.own}) begin miscmp++; $display("FAIL out_rsp_vld: got %b want %b", {bus.r0_rsp_vld, bus.r1_rsp_vld}, {~e.own, e.own}); end
    vec++; if (bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin miscmp++; $display("FAIL out_rsp: got %h/%b want %h/%b", bus.rsp_data, bus.rsp_err, e.data, e.err); end
    vec++; if (bus.r1_req_rdy !== 1'b0) begin miscmp++; $display("FAIL resp_no_rdy: got %b want 0", bus.r1_req_rdy); end
    cyc();
    vec++; if ({bus.r1_req_rdy, bus.busy, bus.r0_rsp_vld} !== 3'b100) begin miscmp++; $display("FAIL pending_grant: got rdy/busy/rsp=%b want 100", {bus.r1_req_rdy, bus.busy, bus.r0_rsp_vld}); end
    sb.push_back('{1'b1, 8'h00, 1'b0});
    cyc();
    bus.r1_req_vld = 0;
    vec++; if (bus.io_out_data !== 8'h99) begin miscmp++; $display("FAIL out_data_r1: got %h want 99", bus.io_out_data); end
    cyc();
    e = sb.pop_front();
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld} !== {~e.own, e.own}) begin miscmp++; $display("FAIL r1_rsp_vld: got %b want %b", {bus.r0_rsp_vld, bus.r1_rsp_vld}, {~e.own, e.own}); end
    cyc();
    bus.io_out_rdy = 0;
  endtask

  task automatic test_in();
    bus.r1_req_vld = 1; bus.r1_req_is_in = 1; bus.r1_req_data = 8'h00;
    #1;
    vec++; if ({bus.r0_req_rdy, bus.r1_req_rdy} !== 2'b01) begin miscmp++; $display("FAIL in_grant: got %b want 01", {bus.r0_req_rdy, bus.r1_req_rdy}); end
    sb.push_back('{1'b1, 8'h5A, 1'b0});
    cyc();
    bus.r1_req_vld = 0;
    vec++; if (bus.io_in_rdy !== 1'b1 || bus.io_out_vld !== 1'b0) begin miscmp++; $display("FAIL in_rdy_rise: got in_rdy=%b out_vld=%b want 1 0", bus.io_in_rdy, bus.io_out_vld); end
    cyc(); cyc();
    vec++; if (bus.io_in_rdy !== 1'b1 || bus.r1_rsp_vld !== 1'b0) begin miscmp++; $display("FAIL in_waiting: got in_rdy=%b rsp=%b want 1 0", bus.io_in_rdy, bus.r1_rsp_vld); end
    cyc();
    bus.io_in_vld = 1; bus.io_in_data = 8'h5A;
    cyc();
    bus.io_in_vld = 0; bus.io_in_data = 8'h00;
    e = sb.pop_front();
    vec++; if (bus.io_in_rdy !== 1'b0) begin miscmp++; $display("FAIL in_rdy_drop: got %b want 0", bus.io_in_rdy); end
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld} !== {~e.own, e.own}) begin miscmp++; $display("FAIL in_rsp_vld: got %b want %b", {bus.r0_rsp_vld, bus.r1_rsp_vld}, {~e.own, e.own}); end
    vec++; if (bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin miscmp++; $display("FAIL in_rsp: got %h/%b want %h/%b", bus.rsp_data, bus.rsp_err, e.data, e.err); end
    cyc();
    vec++; if (bus.r1_rsp_vld !== 1'b0 || bus.rsp_data !== 8'h5A) begin miscmp++; $display("FAIL in_hold: got rsp=%b data=%h want 0 5a", bus.r1_rsp_vld, bus.rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic exp_own;
    int ngnt, nrsp;
    rst = 1; cyc(); rst = 0;
    bus.io_out_rdy = 1; bus.io_in_vld = 1; bus.io_in_data = 8'h77;
    bus.r0_req_vld = 1; bus.r0_req_is_in = 0; bus.r0_req_data = 8'h11;
    bus.r1_req_vld = 1; bus.r1_req_is_in = 1; bus.r1_req_data = 8'h00;
    exp_own = 0; ngnt = 0; nrsp = 0;
    for (int i = 0; i < 60 && (ngnt < 4 || nrsp < 4); i++) begin
      if (ngnt == 4) begin bus.r0_req_vld = 0; bus.r1_req_vld = 0; end
      #1;
      if (bus.r0_rsp_vld | bus.r1_rsp_vld) begin
        vec++;
        if (sb.size() == 0) begin miscmp++; $display("FAIL rr_extra_rsp: got rsp %b want none", {bus.r0_rsp_vld, bus.r1_rsp_vld}); end
        else begin
          e = sb.pop_front();
          if ({bus.r0_rsp_vld, bus.r1_rsp_vld, bus.rsp_data, bus.rsp_err} !== {~e.own, e.own, e.data, e.err}) begin
            miscmp++; $display("FAIL rr_rsp%0d: got vld=%b data=%h err=%b want vld=%b data=%h err=%b", nrsp,
              {bus.r0_rsp_vld, bus.r1_rsp_vld}, bus.rsp_data, bus.rsp_err, {~e.own, e.own}, e.data, e.err);
          end
        end
        nrsp++;
      end
      if ((bus.r0_req_rdy | bus.r1_req_rdy) && ngnt < 4) begin
        vec++;
        if ({bus.r0_req_rdy, bus.r1_req_rdy} !== {~exp_own, exp_own}) begin
          miscmp++; $display("FAIL rr_grant%0d: got %b want %b", ngnt, {bus.r0_req_rdy, bus.r1_req_rdy}, {~exp_own, exp_own});
        end
        sb.push_back('{exp_own, exp_own ? 8'h77 : 8'h00, 1'b0});
        exp_own = ~exp_own;
        ngnt++;
      end
      cyc();
    end
    vec++; if (ngnt != 4 || nrsp != 4) begin miscmp++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 4 4", ngnt, nrsp); end
    bus.r0_req_vld = 0; bus.r1_req_vld = 0;
    bus.io_out_rdy = 0; bus.io_in_vld = 0;
    sb.delete();
    cyc(); cyc();
  endtask

  task automatic test_timeout();
    int n;
    bus.r0_req_vld = 1; bus.r0_req_is_in = 0; bus.r0_req_data = 8'h33;
    #1;
    vec++; if (bus.r0_req_rdy !== 1'b1) begin miscmp++; $display("FAIL to_grant: got %b want 1", bus.r0_req_rdy); end
    sb.push_back('{1'b0, 8'h00, 1'b1});
    cyc();
    bus.r0_req_vld = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.r0_rsp_vld | bus.r1_rsp_vld) break;
      if (bus.io_out_vld) n++;
      cyc();
    end
    e = sb.pop_front();
    vec++; if (n != 8) begin miscmp++; $display("FAIL to_vld_cycles: got %0d want 8", n); end
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld, bus.rsp_data, bus.rsp_err} !== {~e.own, e.own, e.data, e.err}) begin
      miscmp++; $display("FAIL to_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
        {bus.r0_rsp_vld, bus.r1_rsp_vld}, bus.rsp_data, bus.rsp_err, {~e.own, e.own}, e.data, e.err);
    end
    cyc();
    bus.r1_req_vld = 1; bus.r1_req_is_in = 0; bus.r1_req_data = 8'h44;
    #1;
    vec++; if (bus.r1_req_rdy !== 1'b1) begin miscmp++; $display("FAIL late_grant: got %b want 1", bus.r1_req_rdy); end
    sb.push_back('{1'b1, 8'h00, 1'b0});
    cyc();
    bus.r1_req_vld = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.r0_rsp_vld | bus.r1_rsp_vld) break;
      if (bus.io_out_vld) n++;
      bus.io_out_rdy = (n == 8) && bus.io_out_vld;
      cyc();
    end
    bus.io_out_rdy = 0;
    e = sb.pop_front();
    vec++; if (n != 8) begin miscmp++; $display("FAIL late_vld_cycles: got %0d want 8", n); end
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld, bus.rsp_data, bus.rsp_err} !== {~e.own, e.own, e.data, e.err}) begin
      miscmp++; $display("FAIL late_hs_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
        {bus.r0_rsp_vld, bus.r1_rsp_vld}, bus.rsp_data, bus.rsp_err, {~e.own, e.own}, e.data, e.err);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.r1_req_vld = 1; bus.r1_req_is_in = 1;
    #1;
    vec++; if (bus.r1_req_rdy !== 1'b1) begin miscmp++; $display("FAIL rm_grant: got %b want 1", bus.r1_req_rdy); end
    cyc();
    bus.r1_req_vld = 0;
    vec++; if (bus.io_in_rdy !== 1'b1) begin miscmp++; $display("FAIL rm_in_rdy: got %b want 1", bus.io_in_rdy); end
    cyc();
    rst = 1;
    #1;
    vec++; if ({bus.io_in_rdy, bus.busy} !== 2'b00) begin miscmp++; $display("FAIL rm_async: got in_rdy/busy=%b want 00", {bus.io_in_rdy, bus.busy}); end
    cyc(); cyc();
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld} !== 2'b00) begin miscmp++; $display("FAIL rm_no_rsp: got %b want 00", {bus.r0_rsp_vld, bus.r1_rsp_vld}); end
    bus.r1_req_vld = 1; bus.r1_req_is_in = 1;
    rst = 0;
    #1;
    vec++; if (bus.r1_req_rdy !== 1'b1) begin miscmp++; $display("FAIL rm_regrant: got %b want 1", bus.r1_req_rdy); end
    sb.push_back('{1'b1, 8'hC3, 1'b0});
    bus.io_in_vld = 1; bus.io_in_data = 8'hC3;
    cyc();
    bus.r1_req_vld = 0;
    cyc();
    bus.io_in_vld = 0;
    e = sb.pop_front();
    vec++; if ({bus.r0_rsp_vld, bus.r1_rsp_vld, bus.rsp_data, bus.rsp_err} !== {~e.own, e.own, e.data, e.err}) begin
      miscmp++; $display("FAIL rm_rsp: got vld=%b data=%h err=%b want vld=%b data=%h err=%b",
        {bus.r0_rsp_vld, bus.r1_rsp_vld}, bus.rsp_data, bus.rsp_err, {~e.own, e.own}, e.data, e.err);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_out_single();
    test_in();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
